// File: rtl/fpu_conv_issue_pkg.sv
// Shared FPU conversion types and constants for the int-to-float issue/collect slice.
package fpu_conv_issue_pkg;

  localparam int FP_W      = 32;
  localparam int TAG_W_DEF = 6;

  typedef struct packed {
    logic [FP_W-1:0]      data;
    logic [TAG_W_DEF-1:0] tag;
  } res_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fpu_conv_fifo.sv
// DEPTH-entry synchronous result FIFO with occupancy count; head is read from registered storage.
module fpu_conv_fifo
  import fpu_conv_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        push,
  input  logic [FP_W-1:0]             push_data,
  input  logic [TAG_W-1:0]            push_tag,
  input  logic                        pop,
  output logic [FP_W-1:0]             head_data,
  output logic [TAG_W-1:0]            head_tag,
  output logic [cnt_w(DEPTH)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [FP_W-1:0]  data_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard both ends so an empty pop or a full push can never corrupt state.
  always_comb begin
    push_ok_s = push && (count_r != CNT_FULL);
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Storage, pointers (natural power-of-two wrap) and occupancy update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {FP_W{1'b0}};
        tag_mem_r[i]  <= {TAG_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        data_mem_r[wr_ptr_r] <= push_data;
        tag_mem_r[wr_ptr_r]  <= push_tag;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = data_mem_r[rd_ptr_r];
  assign head_tag  = tag_mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fpu_conv_issue.sv
// Issue/collect stage around the registered int-to-float converter, with a credit-guarded result FIFO.
// Optional FPU_CONV_STATS_EN adds wrap-around accept (stat_conv) and stall (stat_stall) counters.
module fpu_conv_issue
  import fpu_conv_issue_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [FP_W-1:0]  conv_x,
  input  logic [FP_W-1:0]  conv_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef FPU_CONV_STATS_EN
  ,
  output logic [31:0]      stat_conv,
  output logic [31:0]      stat_stall
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic             s1_valid_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W:0]   credit_s;
  logic             in_ready_s;
  logic             accept_s;

  // Credit counts the in-flight slot; a same-cycle pop is deliberately not credited.
  always_comb begin
    credit_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, s1_valid_r};
    in_ready_s = rstn && (credit_s < CREDIT_MAX);
    accept_s   = in_valid && in_ready_s;
  end

  // S0 -> S1: remember that the converter holds a live operand and where its result goes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_tag_r <= in_tag;
      end
    end
  end

  fpu_conv_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (s1_valid_r),
    .push_data (conv_y),
    .push_tag  (s1_tag_r),
    .pop       (out_ready),
    .head_data (out_data),
    .head_tag  (out_tag),
    .count     (count_s)
  );

  assign conv_x    = in_x;
  assign in_ready  = in_ready_s;
  assign out_valid = (count_s != {CNT_W{1'b0}});
  assign busy      = s1_valid_r || (count_s != {CNT_W{1'b0}});

`ifdef FPU_CONV_STATS_EN
  logic [31:0] stat_conv_r;
  logic [31:0] stat_stall_r;

  // Free-running accept and stall counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_conv_r  <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (accept_s) begin
        stat_conv_r <= stat_conv_r + 32'd1;
      end
      if (in_valid && !in_ready_s) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_conv  = stat_conv_r;
  assign stat_stall = stat_stall_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fpu_conv_issue.sv
// Directed bench for fpu_conv_issue with a registered int-to-float converter model and a result scoreboard.
module tb_fpu_conv_issue;
  import fpu_conv_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [5:0]  in_tag;
  logic [31:0] conv_x;
  logic [31:0] conv_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic        busy;
`ifdef FPU_CONV_STATS_EN
  logic [31:0] stat_conv;
  logic [31:0] stat_stall;
`endif

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  int   exp_conv = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  fpu_conv_issue dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .conv_x    (conv_x),
    .conv_y    (conv_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
`ifdef FPU_CONV_STATS_EN
    ,
    .stat_conv (stat_conv),
    .stat_stall(stat_stall)
`endif
  );

  // Reference int32 -> IEEE single conversion, round to nearest even.
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    int          e;
    logic [23:0] mant;
    logic [24:0] r;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (32'd0 - x) : x;
    e = 31;
    while (m[31] == 1'b0) begin
      m = m << 1;
      e = e - 1;
    end
    mant = {1'b1, m[30:8]};
    r = {1'b0, mant};
    if (m[7] && ((|m[6:0]) || mant[0])) r = r + 25'd1;
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    return {s, 8'(e + 127), r[22:0]};
  endfunction

  // External converter: one-cycle registered result.
  always @(posedge clk) conv_y <= i2f(conv_x);

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  // Scoreboard: compare pops first, then record accepts for the coming edge.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      exp_conv  = 0;
      exp_stall = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", {26'd0, out_tag, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(res_t'{data: i2f(in_x), tag: in_tag});
        exp_conv++;
      end
      if (in_valid && !in_ready) exp_stall++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until an edge accepts it.
  task automatic send(input logic [31:0] x, input logic [5:0] tag);
    logic acc;
    int   n;
    in_x     = x;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 30) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_d [3];
    logic [5:0]  got_t [3];
    int          ng;

    rstn      = 1'b0;
    in_valid  = 1'b1;
    in_x      = 32'd9;
    in_tag    = 6'd7;
    out_ready = 1'b1;

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    tick();
    rstn     = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Single op: two-cycle latency, one-cycle output.
    tick();
    send(32'd1, 6'd5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_lat1_valid", 64'(out_valid), 64'd0);
    chk("single_lat1_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'h3F80_0000);
    chk("single_tag", 64'(out_tag), 64'd5);
    tick();
    @(negedge clk);
    chk("single_gone", 64'(out_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Back-to-back stream; order and values captured as they leave.
    tick();
    fork
      begin
        send(32'd3, 6'd1);
        send(32'hFFFF_FFFF, 6'd2);
        send(32'd0, 6'd3);
        in_valid = 1'b0;
      end
      begin
        ng = 0;
        for (int c = 0; c < 15 && ng < 3; c++) begin
          @(negedge clk);
          if (out_valid) begin
            got_d[ng] = out_data;
            got_t[ng] = out_tag;
            ng++;
          end
        end
      end
    join
    chk("b2b_count", 64'(ng), 64'd3);
    chk("b2b_d0", 64'(got_d[0]), 64'h4040_0000);
    chk("b2b_d1", 64'(got_d[1]), 64'hBF80_0000);
    chk("b2b_d2", 64'(got_d[2]), 64'h0000_0000);
    chk("b2b_t0", 64'(got_t[0]), 64'd1);
    chk("b2b_t1", 64'(got_t[1]), 64'd2);
    chk("b2b_t2", 64'(got_t[2]), 64'd3);
    drain();

    // Backpressure: only DEPTH accepts while writeback stalls.
    out_ready = 1'b0;
    send(32'd10, 6'd10);
    send(32'd11, 6'd11);
    in_x     = 32'd12;
    in_tag   = 6'd12;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_head_tag", 64'(out_tag), 64'd10);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_same_cycle_credit", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second_tag", 64'(out_tag), 64'd11);
    tick();
    in_valid = 1'b0;
    drain();
`ifdef FPU_CONV_STATS_EN
    @(negedge clk);
    chk("stat_conv", 64'(stat_conv), 64'(exp_conv));
    chk("stat_stall", 64'(stat_stall), 64'(exp_stall));
`endif

    // Sustained push/pop over pointer wrap, including rounding cases.
    tick();
    for (int i = 0; i < 10; i++) begin
      send((i % 3 == 0) ? 32'h0100_0001 + 32'(i) : $urandom(), 6'(20 + i));
    end
    in_valid = 1'b0;
    drain();
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Mid-flight reset discards the in-flight request.
    tick();
    send(32'd7, 6'd33);
    in_valid = 1'b0;
    rstn     = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_out", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      tick();
    end
`ifdef FPU_CONV_STATS_EN
    chk("midrst_stat_conv", 64'(stat_conv), 64'd0);
`endif
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
